mem_fabric_arb: RTL and testbench
=================================

// Module: mem_fabric_arb
// PURPOSE
//   Per-bank request arbiter directly upstream of mem_fabric. Collects one request per client
//   (client index + target bank) and round-robin arbitrates each bank independently. Produces
//   the registered per-bank select vector that drives mem_fabric.client_to_send, plus a
//   per-client grant telling the client to drive its 256-bit data_in in that cycle.
// PARAMETERS
//   N_CLIENTS   16  number of requesting clients (data_in ports of mem_fabric)
//   N_BANKS     16  number of memory banks (data_out ports of mem_fabric)
//   MAX_LOCK    8   max consecutive locked grants per bank (only with MEM_FABRIC_ARB_LOCK_EN)
// PORTS
//   clk            in   1              clock
//   rst            in   1              synchronous reset, active-high
//   req_valid      in   N_CLIENTS      client i requests a transfer this cycle
//   req_bank       in   N_CLIENTS x 4  target bank of client i
//   req_lock       in   N_CLIENTS      client i asks to keep its bank next cycle (burst)
//   grant          out  N_CLIENTS      client i owns its bank this cycle; drives data_in[i]
//   client_to_send out  N_BANKS x 5    per bank {vld, idx[3:0]}; vld=0 -> bank idle
// BEHAVIOUR
//   - Reset: grant=0, client_to_send=0 (all banks idle), all RR pointers=0, lock state cleared.
//   - Arbitration combinational on current-cycle inputs; grant and client_to_send registered.
//     Latency: req_valid in cycle t -> grant/client_to_send in cycle t+1.
//   - Handshake: req_valid in a cycle where grant=1 is a request for the NEXT beat. A client
//     with one beat drops req_valid in its grant cycle. Client holds req_bank stable while
//     req_valid=1; changing req_bank while valid is legal, new bank takes effect that cycle.
//   - Per bank b: candidates = {i : req_valid[i] && req_bank[i]==b}. Winner = first candidate
//     at or after rr_ptr[b] (wrapping N_CLIENTS-1 -> 0). On grant rr_ptr[b] <= winner+1 (mod N).
//     No candidates: bank idle next cycle, rr_ptr unchanged.
//   - A client targets one bank, so at most one grant per client; banks never conflict.
//   - grant[i] = 1 in t+1 iff client_to_send[req_bank_t[i]] == {1, i} in t+1 (consistent).
//   - Fairness: with K continuous requesters on a bank, each granted once every K cycles.
//   - Reset mid-burst: all grants and locks dropped next cycle; client must re-request.
// CONFIGURATION
//   MEM_FABRIC_ARB_LOCK_EN defined:
//     - Per-bank lock state {locked, owner, cnt}. If bank winner has req_lock=1, bank locks to
//       it: while owner keeps req_valid=1 to same bank and req_lock=1, owner wins regardless of
//       rr_ptr. rr_ptr not advanced during lock; advanced to owner+1 on release.
//     - Release when owner drops req_valid, req_lock, changes bank, or cnt reaches MAX_LOCK
//       consecutive grants (forced rotation; owner then competes normally by RR).
//   Not defined: req_lock ignored (no flops), pure round-robin every cycle.
// STRUCTURE
//   - mem_fabric_pkg: N_CLIENTS, N_BANKS, CLIENT_IDX_W=4, typedef struct packed
//     {logic vld; logic [3:0] idx;} fab_sel_t (5 bits, matches client_to_send), fab_bank_t.
//   - Sub-module rr_arb: N-input round-robin arbiter with pointer flop and sync rst, outputs
//     one-hot winner + index; instantiated N_BANKS times via generate. Top holds request
//     decode, lock logic and output registers.
// TESTING
//   1. Reset: rst=1 with all req_valid=1 -> grant=0, client_to_send all 5'h00 every cycle.
//   2. Single req: client 3 -> bank 7 one cycle -> next cycle grant[3]=1, cts[7]=5'h13, others 0;
//      following cycle all idle.
//   3. RR: clients 0,5,9 hold req to bank 2 -> cts[2] = 5'h10,5'h15,5'h19,5'h10,... grants match.
//   4. Parallel: client i -> bank 15-i all 16 valid -> every grant=1, cts[15-i]={1,i} same cycle.
//   5. Lock (LOCK_EN, MAX_LOCK=8): clients 1,4 -> bank 0, client 1 req_lock=1 -> cts[0]=5'h11
//      for 8 cycles, then 5'h14; without macro alternates 5'h11/5'h14.
//   6. Reset mid-stream: rst pulsed during scenario 3 -> outputs 0 next cycle, RR restarts at 0.

Source files
------------

// File: rtl/mem_fabric_pkg.sv
// mem_fabric_pkg: shared sizes and select/bank types for the mem_fabric request arbiter
package mem_fabric_pkg;
    localparam int N_CLIENTS = 16;
    localparam int N_BANKS = 16;
    localparam int CLIENT_IDX_W = 4;
    localparam int BANK_W = 4;
    localparam int MAX_LOCK = 8;
    localparam int LOCK_CNT_W = $clog2(MAX_LOCK + 1);
    typedef logic [BANK_W-1:0] fab_bank_t;
    typedef struct packed {
        logic vld;
        logic [CLIENT_IDX_W-1:0] idx;
    } fab_sel_t;
endpackage

// File: rtl/mem_fabric_arb_rr_arb.sv
// rr_arb: N-input round-robin arbiter, pointer moves past the winner when i_en is set
module rr_arb #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_gnt,
    output logic         o_vld,
    output logic [W-1:0] o_idx
);
    logic [W-1:0] r_ptr;
    logic [W-1:0] w_j;
    always_comb begin
        o_vld = 1'b0;
        o_idx = '0;
        w_j = '0;
        for (int k = 0; k < N; k++) begin
            w_j = W'((int'(r_ptr) + k) % N);
            if (!o_vld && i_req[w_j]) begin
                o_vld = 1'b1;
                o_idx = w_j;
            end
        end
    end
    assign o_gnt = o_vld ? {{(N-1){1'b0}}, 1'b1} << o_idx : '0;
    always_ff @(posedge clk) begin
        if (rst) r_ptr <= '0;
        else if (i_en && o_vld) r_ptr <= (o_idx == W'(N-1)) ? '0 : o_idx + 1'b1;
    end
endmodule

// File: rtl/mem_fabric_arb.sv
// mem_fabric_arb: per-bank round-robin request arbiter feeding mem_fabric; MEM_FABRIC_ARB_LOCK_EN adds burst locking
module mem_fabric_arb
    import mem_fabric_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic      [N_CLIENTS-1:0]     i_req_valid,
    input  fab_bank_t [N_CLIENTS-1:0]     i_req_bank,
    input  logic      [N_CLIENTS-1:0]     i_req_lock,
    output logic      [N_CLIENTS-1:0]     o_grant,
    output fab_sel_t  [N_BANKS-1:0]       o_client_to_send
);
    logic [N_BANKS-1:0][N_CLIENTS-1:0] w_req;
    logic [N_BANKS-1:0][N_CLIENTS-1:0] w_bank_gnt;
    fab_sel_t [N_BANKS-1:0] w_sel;
    logic [N_CLIENTS-1:0] w_grant;
    logic [N_CLIENTS-1:0] r_grant;
    fab_sel_t [N_BANKS-1:0] r_cts;
    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        logic w_vld;
        logic w_en;
        logic [CLIENT_IDX_W-1:0] w_idx;
        logic [N_CLIENTS-1:0] w_gnt;
        for (genvar i = 0; i < N_CLIENTS; i++) begin : g_dec
            assign w_req[b][i] = i_req_valid[i] && i_req_bank[i] == BANK_W'(b);
        end
        rr_arb #(.N(N_CLIENTS), .W(CLIENT_IDX_W)) u_arb (
            .clk   (clk),
            .rst   (rst),
            .i_req (w_req[b]),
            .i_en  (w_en),
            .o_gnt (w_gnt),
            .o_vld (w_vld),
            .o_idx (w_idx)
        );
`ifdef MEM_FABRIC_ARB_LOCK_EN
        logic r_locked;
        logic [CLIENT_IDX_W-1:0] r_owner;
        logic [LOCK_CNT_W-1:0] r_cnt;
        logic w_hit;
        // the owner bypasses the pointer, which already sits at owner+1 from the locking grant
        assign w_hit = r_locked && w_req[b][r_owner] && i_req_lock[r_owner] && r_cnt < LOCK_CNT_W'(MAX_LOCK);
        assign w_en = !w_hit;
        assign w_sel[b] = w_hit ? {1'b1, r_owner} : {w_vld, w_idx};
        assign w_bank_gnt[b] = w_hit ? N_CLIENTS'(1) << r_owner : w_gnt;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_locked <= 1'b0;
                r_owner <= '0;
                r_cnt <= '0;
            end else if (w_hit) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_vld && i_req_lock[w_idx]) begin
                r_locked <= 1'b1;
                r_owner <= w_idx;
                r_cnt <= LOCK_CNT_W'(1);
            end else begin
                r_locked <= 1'b0;
            end
        end
`else
        assign w_en = 1'b1;
        assign w_sel[b] = {w_vld, w_idx};
        assign w_bank_gnt[b] = w_gnt;
`endif
    end
`ifndef MEM_FABRIC_ARB_LOCK_EN
    logic w_unused;
    assign w_unused = ^i_req_lock;
`endif
    always_comb begin
        w_grant = '0;
        for (int b = 0; b < N_BANKS; b++) w_grant = w_grant | w_bank_gnt[b];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= '0;
            r_cts <= '0;
        end else begin
            r_grant <= w_grant;
            r_cts <= w_sel;
        end
    end
    assign o_grant = r_grant;
    assign o_client_to_send = r_cts;
endmodule

// File: tb/tb_mem_fabric_arb.sv
// tb_mem_fabric_arb: directed scenarios plus randomized traffic against a behavioural per-bank RR model
module tb_mem_fabric_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] req_valid = '0;
    logic [15:0][3:0] req_bank = '0;
    logic [15:0] req_lock = '0;
    logic [15:0] grant;
    logic [15:0][4:0] cts;
    int n_cmp = 0;
    int n_err = 0;
    int ptr [16];
    bit lk [16];
    int own [16];
    int cnt [16];

    mem_fabric_arb dut (
        .clk              (clk),
        .rst              (rst),
        .i_req_valid      (req_valid),
        .i_req_bank       (req_bank),
        .i_req_lock       (req_lock),
        .o_grant          (grant),
        .o_client_to_send (cts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [15:0] eg;
        logic [15:0][4:0] ec;
        int win;
        int c;
        eg = '0;
        ec = '0;
        for (int b = 0; b < 16; b++) begin
            if (rst) begin
                ptr[b] = 0;
                lk[b] = 0;
                own[b] = 0;
                cnt[b] = 0;
            end else begin
                win = -1;
`ifdef MEM_FABRIC_ARB_LOCK_EN
                if (lk[b] && req_valid[own[b]] && int'(req_bank[own[b]]) == b && req_lock[own[b]] && cnt[b] < 8) begin
                    win = own[b];
                    cnt[b]++;
                end else
`endif
                begin
                    for (int k = 0; k < 16; k++) begin
                        c = (ptr[b] + k) % 16;
                        if (win < 0 && req_valid[c] && int'(req_bank[c]) == b) win = c;
                    end
                    if (win >= 0) ptr[b] = (win + 1) % 16;
`ifdef MEM_FABRIC_ARB_LOCK_EN
                    lk[b] = win >= 0 && req_lock[win];
                    own[b] = win;
                    cnt[b] = 1;
`endif
                end
                if (win >= 0) begin
                    eg[win] = 1'b1;
                    ec[b] = {1'b1, 4'(win)};
                end
            end
        end
        @(posedge clk);
        #1;
        chk("grant", 80'(grant), 80'(eg));
        chk("cts", cts, ec);
    endtask

    initial begin
        logic [4:0] exp_seq [6];
        exp_seq = '{5'h10, 5'h15, 5'h19, 5'h10, 5'h15, 5'h19};
        req_valid = '1;
        for (int i = 0; i < 16; i++) req_bank[i] = 4'($urandom_range(15));
        repeat (3) step();
        chk("rst_cts", cts, 80'h0);
        rst = 1'b0;
        req_valid = '0;
        req_valid[3] = 1'b1;
        req_bank[3] = 4'd7;
        step();
        chk("single_cts7", 80'(cts[7]), 80'h13);
        chk("single_grant", 80'(grant), 80'h0008);
        req_valid = '0;
        step();
        chk("single_idle", cts, 80'h0);
        req_bank[0] = 4'd2;
        req_bank[5] = 4'd2;
        req_bank[9] = 4'd2;
        req_valid[0] = 1'b1;
        req_valid[5] = 1'b1;
        req_valid[9] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_cts2", 80'(cts[2]), 80'(exp_seq[k]));
        end
        rst = 1'b1;
        step();
        chk("midrst_cts", cts, 80'h0);
        rst = 1'b0;
        step();
        chk("midrst_restart", 80'(cts[2]), 80'h10);
        req_valid = '1;
        for (int i = 0; i < 16; i++) req_bank[i] = 4'(15 - i);
        step();
        chk("par_grant", 80'(grant), 80'hffff);
        chk("par_cts0", 80'(cts[0]), 80'h1f);
        req_valid = '0;
        req_valid[1] = 1'b1;
        req_valid[4] = 1'b1;
        req_bank[1] = 4'd0;
        req_bank[4] = 4'd0;
        req_lock[1] = 1'b1;
        for (int k = 0; k < 18; k++) begin
            step();
`ifdef MEM_FABRIC_ARB_LOCK_EN
            chk("lock_cts0", 80'(cts[0]), (k % 9 == 8) ? 80'h14 : 80'h11);
`else
            chk("lock_cts0", 80'(cts[0]), (k % 2 == 1) ? 80'h14 : 80'h11);
`endif
        end
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(63) == 0);
            req_valid = 16'($urandom);
            req_lock = 16'($urandom);
            for (int i = 0; i < 16; i++) req_bank[i] = 4'($urandom_range(3));
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
